// File: rtl/rsp_s1_prep_ahbic_rr_arb.sv
// rsp_s1_prep_ahbic_rr_arb
//
// Round-robin arbiter for one AHB interconnect output stage. It selects which
// of four input stages is routed in the address phase. A grant can be held
// for a locked sequence, or for the remaining beats of a fixed-length burst.
//
// Parameters
//   BURST_HOLD    1: hold the grant for a whole defined-length burst
//                 0: re-arbitrate at every beat boundary
//
// Ports
//   HCLK          system clock, rising edge
//   HRESET        asynchronous, active-high reset
//   req_port0..3  request from input stage n (held_tran & sel)
//   HREADYM       muxed HREADY; all state advances only when it is 1
//   HSELM         HSEL of the currently routed port
//   HTRANSM[1:0]  HTRANS of the routed port
//   HBURSTM[2:0]  HBURST of the routed port
//   HMASTLOCKM    routed lock, already masked upstream
//   addr_in_port  registered index of the port routed in the address phase
//   no_port       registered; 1 = no port routed
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner, no_port = 1
// GRANT   | owner routed for a single or undefined-length transfer
// BURST   | owner held while fixed-length burst beats remain
// LOCK    | owner held while HMASTLOCKM is asserted

module rsp_s1_prep_ahbic_rr_arb #(
    parameter bit BURST_HOLD = 1'b1
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       req_port0,
    input  logic       req_port1,
    input  logic       req_port2,
    input  logic       req_port3,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    input  logic       HMASTLOCKM,
    output logic [1:0] addr_in_port,
    output logic       no_port
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BURST = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] addr_in_port_q, addr_in_port_d;
    logic       no_port_q, no_port_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic [1:0] last_grant_q, last_grant_d;

    logic [3:0] req_vec;
    logic       rr_found;
    logic [1:0] rr_winner;
    logic [3:0] burst_len;

    // The burst length is encoded in HBURSTM[2:1]; the wrap/incr bit has no
    // effect on how long the grant is held.
    logic       unused_hburst_lsb;
    assign unused_hburst_lsb = HBURSTM[0];

    assign req_vec = {req_port3, req_port2, req_port1, req_port0};

    // Remaining beats after the NONSEQ: INCR4/WRAP4 -> 3, 8 -> 7, 16 -> 15.
    always_comb begin
        burst_len = 4'd0;
        case (HBURSTM[2:1])
            2'b01:   burst_len = 4'd3;
            2'b10:   burst_len = 4'd7;
            2'b11:   burst_len = 4'd15;
            default: burst_len = 4'd0;
        endcase
    end

    // Round-robin search: start one past the last granted port, first hit wins.
    always_comb begin
        logic [1:0] cand;
        rr_found  = 1'b0;
        rr_winner = 2'd0;
        cand      = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant_q + 2'(i);
            if (!rr_found && req_vec[cand]) begin
                rr_found  = 1'b1;
                rr_winner = cand;
            end
        end
    end

    always_comb begin
        logic       has_owner;
        logic       lock_hold;
        logic       burst_start;
        logic       reload_ok;
        logic [3:0] cnt_next;

        state_d        = state_q;
        addr_in_port_d = addr_in_port_q;
        no_port_d      = no_port_q;
        beat_cnt_d     = beat_cnt_q;
        last_grant_d   = last_grant_q;

        has_owner   = !no_port_q;
        lock_hold   = has_owner && HMASTLOCKM;
        burst_start = 1'b0;
        reload_ok   = 1'b0;
        cnt_next    = beat_cnt_q;

        if (HREADYM) begin
            case (HTRANSM)
                TRANS_SEQ: begin
                    // Saturate at zero so a stray SEQ cannot wrap the count.
                    if (beat_cnt_q != 4'd0) begin
                        cnt_next = beat_cnt_q - 4'd1;
                    end
                end
                TRANS_BUSY: begin
                    cnt_next = beat_cnt_q;
                end
                TRANS_NONSEQ: begin
                    cnt_next    = 4'd0;
                    burst_start = BURST_HOLD && HSELM && has_owner;
                end
                default: begin
                    cnt_next = 4'd0;
                end
            endcase

            // A NONSEQ inside a burst ends it early. The new burst may only
            // claim the hold if the owner keeps the bus anyway, either
            // through a lock or by winning the round-robin again.
            reload_ok = lock_hold || (state_q != ST_BURST) ||
                        (rr_found && (rr_winner == addr_in_port_q));
            if (burst_start && reload_ok) begin
                cnt_next = burst_len;
            end
            if (!has_owner) begin
                cnt_next = 4'd0;
            end

            beat_cnt_d = cnt_next;

            if (lock_hold) begin
                state_d = ST_LOCK;
            end else if (cnt_next != 4'd0) begin
                state_d = ST_BURST;
            end else if (rr_found) begin
                state_d        = ST_GRANT;
                addr_in_port_d = rr_winner;
                no_port_d      = 1'b0;
                if (no_port_q || (rr_winner != addr_in_port_q)) begin
                    last_grant_d = rr_winner;
                end
            end else begin
                state_d   = ST_IDLE;
                no_port_d = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q        <= ST_IDLE;
            addr_in_port_q <= 2'b00;
            no_port_q      <= 1'b1;
            beat_cnt_q     <= 4'd0;
            last_grant_q   <= 2'b11;
        end else begin
            state_q        <= state_d;
            addr_in_port_q <= addr_in_port_d;
            no_port_q      <= no_port_d;
            beat_cnt_q     <= beat_cnt_d;
            last_grant_q   <= last_grant_d;
        end
    end

    assign addr_in_port = addr_in_port_q;
    assign no_port      = no_port_q;

endmodule

// File: doc/rsp_s1_prep_ahbic_rr_arb.md
RSP_S1_PREP_AHBIC_RR_ARB -- requirements
Module: rsp_s1_prep_ahbic_rr_arb

Interface
REQ-001 SHALL have parameter BURST_HOLD, default 1, meaning 1 = hold grant for the whole defined-length burst, 0 = re-arbitrate at every beat boundary.
REQ-002 SHALL have port HCLK, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port HRESET, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have ports req_port0..req_port3, input, 1 each, request from input stage n (held_tran & sel).
REQ-005 SHALL have port HREADYM, input, 1, muxed HREADY; arbitration state advances only when it is 1.
REQ-006 SHALL have port HSELM, input, 1, HSEL of the currently routed port.
REQ-007 SHALL have port HTRANSM, input, 2, HTRANS of the routed port (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
REQ-008 SHALL have port HBURSTM, input, 3, HBURST of the routed port.
REQ-009 SHALL have port HMASTLOCKM, input, 1, routed lock, already masked by HSEL/hsel_lock upstream.
REQ-010 SHALL have port addr_in_port, output, 2, registered index of the port routed in the address phase.
REQ-011 SHALL have port no_port, output, 1, registered; 1 = no port routed.

Function
REQ-012 SHALL implement a 4-state FSM: IDLE (no owner), GRANT (owner, single or INCR transfer), BURST (owner, fixed-length burst beats remaining), LOCK (owner holding a locked sequence).
REQ-013 SHALL hold all registers when HREADYM=0, whatever the inputs do.
REQ-014 SHALL, when HREADYM=1 and not held (REQ-016/017), grant round-robin: search starts at last_grant+1 mod 4, and the first asserted req_portN wins.
REQ-015 SHALL, when no request is asserted during arbitration, set no_port=1, keep addr_in_port unchanged, and enter IDLE.
REQ-016 SHALL hold the current owner (no re-arbitration, stay in LOCK) while HMASTLOCKM=1; leave LOCK when HREADYM=1 and HMASTLOCKM=0.
REQ-017 SHALL, with BURST_HOLD=1, on HREADYM=1, HSELM=1 and HTRANSM=NONSEQ, load beat_cnt with 3/7/15 for HBURSTM 01x/10x/11x, enter BURST and hold the owner.
REQ-018 SHALL treat HBURSTM 000/001 as GRANT (no hold).
REQ-019 SHALL decrement beat_cnt on each HREADYM=1 cycle with HTRANSM=SEQ, hold it on BUSY, and release the grant (re-arbitrate that cycle) when it is decremented from 1.
REQ-020 SHALL, in BURST, treat HTRANSM=IDLE or NONSEQ with HREADYM=1 as early termination: clear beat_cnt and re-arbitrate in the same cycle; a NONSEQ from the retained owner may reload it.
REQ-021 SHALL give LOCK priority over BURST when both apply; when the lock ends, a remaining burst count still holds the owner.
REQ-022 SHALL keep the owner granted during a hold even if its req_portN deasserts.
REQ-023 SHALL, with BURST_HOLD=0, never enter BURST; beat_cnt stays 0.
REQ-024 SHALL update last_grant only when a new grant is registered (no_port 1->0 or index change).
REQ-025 SHALL have a new grant decision take effect one HCLK after the HREADYM=1 cycle that made it (registered outputs, 1-cycle latency).
REQ-026 SHALL hold beat_cnt at 0 (no wrap) if a SEQ arrives with the count already 0.

Reset
REQ-027 SHALL, while HRESET=1, immediately force addr_in_port=2'b00, no_port=1, state=IDLE, beat_cnt=0 and last_grant=2'b11 (port 0 has first priority), including mid-burst or mid-lock.
REQ-028 SHALL begin normal arbitration on the first HCLK rising edge after HRESET deasserts.

Verification
REQ-029 SHALL verify round-robin: req_port0..3 all held at 1 with single NONSEQ transfers and HREADYM=1 -> addr_in_port sequence 0,1,2,3,0 on consecutive cycles, no_port=0.
REQ-030 SHALL verify burst hold: port1 wins with INCR4 (HBURSTM=011) and port2 requesting -> addr_in_port=1 for NONSEQ plus 3 SEQ beats, then 2.
REQ-031 SHALL verify burst hold with waits: INCR8 with a BUSY beat and 2 HREADYM=0 cycles inserted -> owner held until the 7th SEQ completes, beat_cnt never decrements on BUSY or stalled cycles.
REQ-032 SHALL verify lock: port3 has HMASTLOCKM=1 for 5 cycles with all other ports requesting -> addr_in_port=3 throughout; on HMASTLOCKM=0, the next grant is port 0.
REQ-033 SHALL verify early termination: port0 in INCR16, HTRANSM=IDLE after 4 beats while port2 requests -> addr_in_port=2 on the next cycle, beat_cnt=0.
REQ-034 SHALL verify reset: HRESET asserted mid-INCR8 with addr_in_port=2 -> asynchronously no_port=1, addr_in_port=0; after release with port3 and port0 requesting -> port0 is granted first.
